// File: rtl/sd_bus_arbiter.sv
// SPI-mode SD card bus arbiter: init engine owns the bus until done, then read/write
// requesters share it round-robin with a CS-high gap between owners. Optional grant timeout: SD_BUS_ARB_TIMEOUT_EN.
module sd_bus_arbiter #(
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic SD_CLK,
    input  logic rst,
    input  logic init_o,
    input  logic init_cs,
    input  logic init_datain,
    input  logic rd_req,
    input  logic rd_done,
    input  logic rd_cs,
    input  logic rd_datain,
    input  logic wr_req,
    input  logic wr_done,
    input  logic wr_cs,
    input  logic wr_datain,
    output logic rd_gnt,
    output logic wr_gnt,
    output logic SD_CS,
    output logic SD_DATAIN,
    output logic busy,
    output logic timeout_err
);
    typedef enum logic [2:0] {S_INIT, S_GAP, S_IDLE, S_RD, S_WR} state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t     state, nxt;
    logic [7:0] gap_cnt;
    logic       last_wr;
    logic       hold_exp;

`ifdef SD_BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] hold_cnt;

    assign hold_exp = (hold_cnt == HOLD_LAST);

    always_ff @(posedge SD_CLK) begin
        if (rst) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (nxt == S_RD || nxt == S_WR)
                hold_cnt <= (state == nxt) ? hold_cnt + 16'd1 : '0;
            // Leaving a grant for the gap without the owner's done means a forced revoke.
            timeout_err <= (nxt == S_GAP) &&
                           ((state == S_RD && !rd_done) || (state == S_WR && !wr_done));
        end
    end
`else
    assign hold_exp    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Re-initialisation overrides every other transition.
    always_comb begin
        nxt = state;
        if (state != S_INIT && !init_o) begin
            nxt = S_INIT;
        end else begin
            case (state)
                S_INIT: if (init_o) nxt = S_GAP;
                S_GAP:  if (gap_cnt == 8'd0) nxt = S_IDLE;
                S_IDLE: begin
                    if (rd_req && (!wr_req || last_wr)) nxt = S_RD;
                    else if (wr_req)                    nxt = S_WR;
                end
                S_RD:   if (rd_done || hold_exp) nxt = S_GAP;
                S_WR:   if (wr_done || hold_exp) nxt = S_GAP;
                default: nxt = S_INIT;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge SD_CLK) begin
        if (rst) begin
            state     <= S_INIT;
            rd_gnt    <= 1'b0;
            wr_gnt    <= 1'b0;
            SD_CS     <= 1'b1;
            SD_DATAIN <= 1'b1;
            busy      <= 1'b1;
            last_wr   <= 1'b1;
            gap_cnt   <= 8'd0;
        end else begin
            state  <= nxt;
            rd_gnt <= (nxt == S_RD);
            wr_gnt <= (nxt == S_WR);
            busy   <= (nxt != S_IDLE);
            case (nxt)
                S_INIT:  begin SD_CS <= init_cs; SD_DATAIN <= init_datain; end
                S_RD:    begin SD_CS <= rd_cs;   SD_DATAIN <= rd_datain;   end
                S_WR:    begin SD_CS <= wr_cs;   SD_DATAIN <= wr_datain;   end
                default: begin SD_CS <= 1'b1;    SD_DATAIN <= 1'b1;        end
            endcase
            if (nxt == S_GAP)
                gap_cnt <= (state == S_GAP) ? gap_cnt - 8'd1 : GAP_LAST;
            if (state == S_RD && nxt == S_GAP) last_wr <= 1'b0;
            if (state == S_WR && nxt == S_GAP) last_wr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Bench for sd_bus_arbiter: per-cycle comparison against a behavioural model plus
// directed scenario checks with literal expectations.
module tb_sd_bus_arbiter;
    localparam int GAP = 8;
    localparam int TO  = 16;
`ifdef SD_BUS_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif
    localparam int M_INIT = 0, M_GAP = 1, M_IDLE = 2, M_RD = 3, M_WR = 4;

    logic SD_CLK = 1'b0;
    logic rst, init_o, init_cs, init_datain;
    logic rd_req, rd_done, rd_cs, rd_datain;
    logic wr_req, wr_done, wr_cs, wr_datain;
    logic rd_gnt, wr_gnt, SD_CS, SD_DATAIN, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    sd_bus_arbiter #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .SD_CLK(SD_CLK), .rst(rst), .init_o(init_o), .init_cs(init_cs), .init_datain(init_datain),
        .rd_req(rd_req), .rd_done(rd_done), .rd_cs(rd_cs), .rd_datain(rd_datain),
        .wr_req(wr_req), .wr_done(wr_done), .wr_cs(wr_cs), .wr_datain(wr_datain),
        .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .SD_CS(SD_CS), .SD_DATAIN(SD_DATAIN),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 SD_CLK = ~SD_CLK;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, remaining gap cycles, cycles a grant has been held.
    int   m_own = M_INIT, m_gap = 0, m_hold = 0;
    bit   m_last_rd = 1'b0, m_valid = 1'b0;
    logic e_cs, e_din, e_rg, e_wg, e_busy, e_to;

    always @(posedge SD_CLK) begin : model
        int own, gap, hold;
        bit lastrd, to;
        own = m_own; gap = m_gap; hold = m_hold; lastrd = m_last_rd; to = 1'b0;
        if (rst) begin
            own = M_INIT; gap = 0; hold = 0; lastrd = 1'b0;
        end else if (own != M_INIT && !init_o) begin
            own = M_INIT;
        end else begin
            case (own)
                M_INIT: if (init_o) begin own = M_GAP; gap = GAP; end
                M_GAP: begin
                    gap = gap - 1;
                    if (gap == 0) own = M_IDLE;
                end
                M_IDLE: begin
                    hold = 0;
                    if (rd_req && wr_req) own = lastrd ? M_WR : M_RD;
                    else if (rd_req)      own = M_RD;
                    else if (wr_req)      own = M_WR;
                end
                default: begin
                    hold = hold + 1;
                    if ((own == M_RD && rd_done) || (own == M_WR && wr_done)) begin
                        lastrd = (own == M_RD); own = M_GAP; gap = GAP;
                    end else if (TO_ON && hold == TO) begin
                        lastrd = (own == M_RD); own = M_GAP; gap = GAP; to = 1'b1;
                    end
                end
            endcase
        end
        m_own <= own; m_gap <= gap; m_hold <= hold; m_last_rd <= lastrd; m_valid <= 1'b1;
        e_rg   <= (own == M_RD);
        e_wg   <= (own == M_WR);
        e_busy <= (own != M_IDLE);
        e_to   <= to;
        e_cs   <= (own == M_INIT) ? init_cs : (own == M_RD) ? rd_cs : (own == M_WR) ? wr_cs : 1'b1;
        e_din  <= (own == M_INIT) ? init_datain : (own == M_RD) ? rd_datain :
                  (own == M_WR) ? wr_datain : 1'b1;
    end

    always @(negedge SD_CLK) begin
        if (m_valid) begin
            chk("m_rd_gnt", rd_gnt, e_rg);
            chk("m_wr_gnt", wr_gnt, e_wg);
            chk("m_sd_cs", SD_CS, e_cs);
            chk("m_sd_datain", SD_DATAIN, e_din);
            chk("m_busy", busy, e_busy);
            chk("m_timeout_err", timeout_err, e_to);
            chk("m_gnt_excl", rd_gnt & wr_gnt, 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SD_CLK);
        #1;
    endtask

    // Counts cycles spent busy starting from the current one (gap entered on the last edge).
    task automatic measure_gap(input string nm);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin n++; tick(1); end
        chk_int(nm, n, GAP);
        chk({nm, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_gnt(input bit rd, input string nm);
        int n = 0;
        while ((rd ? rd_gnt : wr_gnt) !== 1'b1 && n < 60) begin n++; tick(1); end
        chk(nm, rd ? rd_gnt : wr_gnt, 1'b1);
    endtask

    task automatic pulse_done(input bit rd);
        if (rd) rd_done = 1'b1; else wr_done = 1'b1;
        tick(1);
        rd_done = 1'b0; wr_done = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; init_o = 1'b0; init_cs = 1'b1; init_datain = 1'b1;
        rd_req = 1'b0; rd_done = 1'b0; rd_cs = 1'b1; rd_datain = 1'b1;
        wr_req = 1'b0; wr_done = 1'b0; wr_cs = 1'b1; wr_datain = 1'b1;
        tick(2);
        chk("rst_cs", SD_CS, 1'b1);
        chk("rst_busy", busy, 1'b1);
        chk("rst_rd_gnt", rd_gnt, 1'b0);
        chk("rst_wr_gnt", wr_gnt, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            init_cs = i[0]; init_datain = ~i[1];
            tick(1);
            chk("init_fwd_cs", SD_CS, init_cs);
            chk("init_fwd_din", SD_DATAIN, init_datain);
            chk("init_busy", busy, 1'b1);
        end
        init_cs = 1'b1; init_datain = 1'b1;
        init_o = 1'b1;
        tick(1);
        measure_gap("init_gap");
        tick(3);
        chk("idle_stays", busy, 1'b0);

        // Simultaneous requests: read wins the first tie, then alternate.
        rd_req = 1'b1; wr_req = 1'b1;
        tick(1);
        chk("tie1_rd", rd_gnt, 1'b1);
        chk("tie1_wr", wr_gnt, 1'b0);
        rd_cs = 1'b0; rd_datain = 1'b0; tick(1);
        rd_datain = 1'b1; tick(1);
        chk("rd_fwd_cs", SD_CS, 1'b0);
        chk("rd_fwd_din", SD_DATAIN, 1'b1);
        rd_cs = 1'b1;
        pulse_done(1'b1);
        chk("rd_done_drop", rd_gnt, 1'b0);
        measure_gap("rd_gap");
        tick(1);
        chk("tie2_wr", wr_gnt, 1'b1);
        chk("tie2_rd", rd_gnt, 1'b0);

        wr_cs = 1'b0; wr_datain = 1'b0;
        pulse_done(1'b1);
        chk("foreign_done_ign", wr_gnt, 1'b1);
        chk("wr_fwd_cs", SD_CS, 1'b0);
        wr_cs = 1'b1; wr_datain = 1'b1;
        pulse_done(1'b0);
        chk("wr_done_drop", wr_gnt, 1'b0);
        chk("wr_gap_busy", busy, 1'b1);
        measure_gap("wr_gap");
        tick(1);
        chk("tie3_rd", rd_gnt, 1'b1);
        // Done in the very first granted cycle is honoured.
        pulse_done(1'b1);
        chk("early_done", rd_gnt, 1'b0);
        rd_req = 1'b0;
        measure_gap("early_gap");
        wait_gnt(1'b0, "wr_only");
        wr_req = 1'b0;
        pulse_done(1'b0);
        measure_gap("wr2_gap");

        // Re-initialisation while read owns the bus.
        rd_req = 1'b1;
        wait_gnt(1'b1, "rd_only");
        tick(2);
        init_o = 1'b0; init_cs = 1'b0; init_datain = 1'b1;
        tick(1);
        chk("reinit_rd_gnt", rd_gnt, 1'b0);
        chk("reinit_cs", SD_CS, 1'b0);
        chk("reinit_busy", busy, 1'b1);
        tick(2);
        init_cs = 1'b1; init_o = 1'b1;
        tick(1);
        measure_gap("reinit_gap");

        // Hold with no done: forced revoke only when the timeout is built in.
        wr_req = 1'b1;
        wait_gnt(1'b1, "hold_rd");
        n = 0;
        while (rd_gnt === 1'b1 && n < 40) begin n++; tick(1); end
        if (TO_ON) begin
            chk_int("hold_len", n, TO);
            chk("timeout_pulse", timeout_err, 1'b1);
            measure_gap("to_gap");
            tick(1);
            chk("to_then_wr", wr_gnt, 1'b1);
            wr_req = 1'b0; rd_req = 1'b0;
            pulse_done(1'b0);
        end else begin
            chk_int("hold_len", n, 40);
            chk("no_timeout", timeout_err, 1'b0);
            rd_req = 1'b0;
            pulse_done(1'b1);
            chk("hold_done_drop", rd_gnt, 1'b0);
        end
        tick(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/sd_bus_arbiter.md
Name: sd_bus_arbiter

Overview:
- Owns the shared SPI-mode SD card pins (SD_CS, SD_DATAIN) and sequences access to them.
- Holds the bus for the initialisation engine until it reports done.
- Then shares the bus between a block-read requester and a block-write requester with round-robin arbitration.
- Enforces a CS-high inter-command gap after every transaction.

Parameters:
- GAP_CYC, 8, SD_CLK cycles SD_CS/SD_DATAIN held high between owners; legal range 1..255.
- TIMEOUT_CYC, 4096, max SD_CLK cycles a grant may be held before forced revoke; used only with the macro; legal range 2..65535.

Ports:
- SD_CLK  in  1  card clock, sole clock
- rst  in  1  synchronous, active-high reset
- init_o  in  1  init engine done level
- init_cs  in  1  init engine chip select
- init_datain  in  1  init engine MOSI
- rd_req  in  1  read requester wants bus (level)
- rd_done  in  1  read transaction finished (1-cycle pulse)
- rd_cs  in  1  read requester chip select
- rd_datain  in  1  read requester MOSI
- wr_req  in  1  write requester wants bus (level)
- wr_done  in  1  write transaction finished (1-cycle pulse)
- wr_cs  in  1  write requester chip select
- wr_datain  in  1  write requester MOSI
- rd_gnt  out  1  read requester owns bus
- wr_gnt  out  1  write requester owns bus
- SD_CS  out  1  to card
- SD_DATAIN  out  1  to card MOSI
- busy  out  1  arbiter not idle
- timeout_err  out  1  forced-revoke pulse (tied 0 without macro)

Behaviour:
- All outputs registered; every output and state changes only on posedge SD_CLK. rst is sampled synchronously.
- Reset values: state=S_INIT, rd_gnt=0, wr_gnt=0, SD_CS=1, SD_DATAIN=1, busy=1, timeout_err=0, last_owner=WR (read wins the first tie), gap_cnt=0.
- Owner pins are forwarded with exactly 1 cycle latency: SD_CS/SD_DATAIN <= selected owner's cs/datain.
- S_INIT:
  - Forwards init_cs/init_datain; busy=1.
  - On init_o=1, go to S_GAP with gap_cnt=GAP_CYC-1.
- S_GAP:
  - SD_CS=1, SD_DATAIN=1, busy=1.
  - gap_cnt decrements each cycle; when gap_cnt==0, go to S_IDLE. Exactly GAP_CYC cycles are spent in S_GAP.
- S_IDLE:
  - SD_CS=1, SD_DATAIN=1, busy=0.
  - rd_req only: go to S_RD, rd_gnt=1 next cycle.
  - wr_req only: go to S_WR, wr_gnt=1 next cycle.
  - Both asserted: grant the requester that is not last_owner.
  - Neither asserted: stay.
- S_RD / S_WR:
  - Forward the granted requester's pins; busy=1.
  - Requests from either side are ignored.
  - On the owner's done pulse: drop the grant next cycle, set last_owner to the owner, go to S_GAP with gap_cnt=GAP_CYC-1.
  - A done pulse from the non-granted requester is ignored.
- Grant and done rules:
  - A requester may drive its pins only while its gnt=1.
  - rd_gnt and wr_gnt are never both 1.
  - A done pulse in the same cycle the grant is first asserted is honoured.
- init_o falls in any state other than S_INIT: next cycle go to S_INIT, clear both grants, and forward init pins (re-initialisation takes precedence over everything).
- A req deasserted before grant: in S_IDLE the decision uses the current-cycle sampled values only; no request is latched.

Optional Feature:
- Macro: SD_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on entry to S_RD/S_WR and increments each cycle while the grant is held.
  - When it reaches TIMEOUT_CYC-1 with no done, the next cycle revokes the grant, pulses timeout_err=1 for one cycle, sets last_owner to the offender, and goes to S_GAP.
  - A done arriving in the same cycle as the timeout is treated as normal completion; no timeout_err.
- Undefined: no counter is instantiated; timeout_err is constant 0; a grant is held indefinitely until done or init_o falls.

Test Plan:
- Reset; hold init_o=0, toggle init_cs/init_datain -> SD_CS/SD_DATAIN follow with 1-cycle delay; busy=1; no grants.
- Raise init_o with GAP_CYC=8 -> SD_CS=1 for exactly 8 cycles, then busy=0 in S_IDLE.
- Assert rd_req and wr_req simultaneously after first idle -> rd_gnt first; after rd_done, 8 gap cycles, then wr_gnt=1. Repeat -> rd wins again (alternation).
- wr granted, pulse rd_done -> ignored, wr_gnt stays 1; pulse wr_done -> wr_gnt=0 next cycle, gap entered.
- init_o drops during rd_gnt=1 -> rd_gnt=0 next cycle, init pins forwarded, busy=1.
- Macro on, TIMEOUT_CYC=16, grant rd with no done -> grant dropped after 16 cycles, timeout_err high 1 cycle, gap, then wr granted if requesting.
